// File: rtl/uart_pkg.sv
// uart_pkg: shared UART receiver types and oversampling constants.
//   state_e  - receiver FSM states
//   OS_RATIO - oversample ticks per bit period
//   OS_MID   - tick count from the start edge to the middle of the start bit
package uart_pkg;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

   localparam int OS_RATIO = 16;
   localparam int OS_MID   = 8;

endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: received-byte handshake between the UART receiver and its consumer.
//   rx_data  - received byte (producer -> consumer)
//   rx_valid - rx_data holds an unacknowledged byte (producer -> consumer)
//   rx_ack   - consumer has taken rx_data (consumer -> producer)
//   master   - receiver side, slave - consumer side
interface uart_rx_if #(parameter int DBITS = 8);

   logic [DBITS-1:0] rx_data;
   logic             rx_valid;
   logic             rx_ack;

   modport master (output rx_data, output rx_valid, input rx_ack);
   modport slave  (input rx_data, input rx_valid, output rx_ack);

endinterface

// File: rtl/uart_os_tick.sv
// uart_os_tick: oversample tick generator, one tick every baud_div_i+1 clocks.
//   clk        - clock
//   rst_n      - asynchronous active-low reset
//   clr_i      - hold the counter at zero and suppress ticks
//   baud_div_i - tick period minus one
//   tick_o     - one-clock tick strobe
module uart_os_tick
   import uart_pkg::*;
#(
   parameter int bbits = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr_i,
   input  logic [bbits-1:0] baud_div_i,
   output logic             tick_o
);

   logic [bbits-1:0] cnt_q, cnt_d;

   assign tick_o = !clr_i && cnt_q == baud_div_i;
   assign cnt_d  = (clr_i || tick_o) ? '0 : cnt_q + 1'b1;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 16x oversampling UART receiver, LSB first, one stop bit.
//   clk         - clock
//   rst_n       - asynchronous active-low reset
//   rxd_i       - asynchronous serial line, idle high
//   baud_div_i  - oversample tick period minus one, stable while busy
//   rx_if       - received-byte handshake (rx_data, rx_valid, rx_ack)
//   frame_err_o - one-cycle pulse when the stop bit is sampled low
//   overrun_o   - sticky, an unacknowledged byte was overwritten
//   busy_o      - receiver is inside a frame
module uart_rx
   import uart_pkg::*;
#(
   parameter int bbits = 16,
   parameter int DBITS = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             rxd_i,
   input  logic [bbits-1:0] baud_div_i,
   uart_rx_if.master        rx_if,
   output logic             frame_err_o,
   output logic             overrun_o,
   output logic             busy_o
);

   localparam int BW = $clog2(DBITS);

   state_e           state_q, state_d;
   logic [1:0]       sync_q;
   logic             prev_q;
   logic             rxd_s;
   logic             tick;
   logic [3:0]       os_q, os_d;
   logic [BW-1:0]    bit_q, bit_d;
   logic [DBITS-1:0] shift_q, shift_d;
   logic [DBITS-1:0] data_q, data_d;
   logic             valid_q, valid_d;
   logic             ferr_q, ferr_d;
   logic             ovr_q, ovr_d;
   logic             busy_q;

   assign rxd_s = sync_q[1];

   // Holding the divider in clear while idle makes tick phase start at the start edge.
   uart_os_tick #(.bbits(bbits)) u_tick (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr_i     (state_q == IDLE),
      .baud_div_i(baud_div_i),
      .tick_o    (tick)
   );

   always_comb begin
      state_d = state_q;
      os_d    = os_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      data_d  = data_q;
      valid_d = valid_q && !rx_if.rx_ack;
      ovr_d   = ovr_q && !(valid_q && rx_if.rx_ack);
      ferr_d  = 1'b0;
      case (state_q)
         IDLE: begin
            os_d = '0;
            // Edge rather than level, so a line stuck low never restarts a frame.
            if (prev_q && !rxd_s) state_d = START;
         end
         START: if (tick) begin
            os_d = os_q + 1'b1;
            if (os_q == 4'(OS_MID - 1)) begin
               os_d    = '0;
               bit_d   = '0;
               state_d = rxd_s ? IDLE : DATA;
            end
         end
         DATA: if (tick) begin
            os_d = os_q + 1'b1;
            if (os_q == 4'(OS_RATIO - 1)) begin
               shift_d = {rxd_s, shift_q[DBITS-1:1]};
               bit_d   = bit_q + 1'b1;
               if (bit_q == BW'(DBITS - 1)) state_d = STOP;
            end
         end
         STOP: if (tick) begin
            os_d = os_q + 1'b1;
            if (os_q == 4'(OS_RATIO - 1)) begin
               state_d = IDLE;
               if (rxd_s) begin
                  data_d  = shift_q;
                  valid_d = 1'b1;
                  // An ack in this same cycle consumes the old byte, so no overrun.
                  ovr_d   = ovr_d || (valid_q && !rx_if.rx_ack);
               end else begin
                  ferr_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q <= IDLE;
         sync_q  <= 2'b11;
         prev_q  <= 1'b1;
         os_q    <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         ovr_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sync_q  <= {sync_q[0], rxd_i};
         prev_q  <= rxd_s;
         os_q    <= os_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
         ovr_q   <= ovr_d;
         busy_q  <= state_d != IDLE;
      end

   assign rx_if.rx_data  = data_q;
   assign rx_if.rx_valid = valid_q;
   assign frame_err_o    = ferr_q;
   assign overrun_o      = ovr_q;
   assign busy_o         = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx; expected outcomes are queued per frame and checked when busy drops.
module tb_uart_rx;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        rxd = 1'b1;
   logic [15:0] bd = 16'd3;
   logic        frame_err, overrun, busy;

   uart_rx_if #(.DBITS(8)) rx_if ();

   uart_rx #(.bbits(16), .DBITS(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .rxd_i      (rxd),
      .baud_div_i (bd),
      .rx_if      (rx_if),
      .frame_err_o(frame_err),
      .overrun_o  (overrun),
      .busy_o     (busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] data;
      logic       valid;
      logic       ferr;
      logic       ovr;
   } exp_t;

   exp_t       sb[$];
   exp_t       e;
   int         n_chk = 0;
   int         n_pass = 0;
   int         lat;
   logic       bprev = 1'b0;
   logic       fpend = 1'b0;
   logic [7:0] rb;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic push(input logic [7:0] d, input logic v, input logic f, input logic o);
      sb.push_back('{d, v, f, o});
   endtask

   task automatic send(input logic [7:0] d, input logic stop);
      int n;
      n = 16 * (int'(bd) + 1);
      rxd = 1'b0;
      repeat (n) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rxd = d[i];
         repeat (n) @(negedge clk);
      end
      rxd = stop;
      repeat (n) @(negedge clk);
      rxd = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   task automatic ack();
      rx_if.rx_ack = 1'b1;
      @(negedge clk);
      rx_if.rx_ack = 1'b0;
      @(negedge clk);
   endtask

   initial forever begin
      @(negedge clk);
      if (fpend) begin
         chk("ferr_pulse_len", frame_err, 0);
         fpend = 1'b0;
      end
      if (!rst_n) bprev = 1'b0;
      else begin
         if (bprev && !busy) begin
            chk("sb_nonempty", sb.size() > 0, 1);
            if (sb.size() > 0) begin
               e = sb.pop_front();
               chk("sb_data", rx_if.rx_data, e.data);
               chk("sb_valid", rx_if.rx_valid, e.valid);
               chk("sb_ferr", frame_err, e.ferr);
               chk("sb_ovr", overrun, e.ovr);
               fpend = e.ferr;
            end
         end
         bprev = busy;
      end
   end

   initial begin
      rx_if.rx_ack = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_data", rx_if.rx_data, 0);
      chk("rst_valid", rx_if.rx_valid, 0);
      chk("rst_ferr", frame_err, 0);
      chk("rst_ovr", overrun, 0);
      chk("rst_busy", busy, 0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      push(8'hA5, 1, 0, 0);
      lat = 0;
      fork
         send(8'hA5, 1'b1);
         begin
            while (!rx_if.rx_valid && lat < 5000) begin
               @(negedge clk);
               lat++;
            end
            chk("a5_latency", lat, 3 + 152 * (int'(bd) + 1));
         end
      join
      ack();
      chk("ack_clears_valid", rx_if.rx_valid, 0);

      push(8'hA5, 0, 0, 0);
      rxd = 1'b0;
      repeat (20) @(negedge clk);
      rxd = 1'b1;
      repeat (80) @(negedge clk);
      chk("glitch_busy", busy, 0);

      bd = 16'd0;
      push(8'hA5, 0, 1, 0);
      send(8'h5A, 1'b0);

      push(8'h3C, 1, 0, 0);
      send(8'h3C, 1'b1);
      push(8'hC3, 1, 0, 1);
      send(8'hC3, 1'b1);
      chk("ovr_set", overrun, 1);
      ack();
      chk("ovr_clr", overrun, 0);
      chk("ovr_valid_clr", rx_if.rx_valid, 0);
      ack();
      chk("idle_ack_valid", rx_if.rx_valid, 0);
      chk("idle_ack_data", rx_if.rx_data, 8'hC3);

      push(8'h24, 1, 0, 0);
      send(8'h24, 1'b1);
      push(8'h81, 1, 0, 0);
      fork
         send(8'h81, 1'b1);
         begin
            repeat (2 + 152 * (int'(bd) + 1)) @(negedge clk);
            rx_if.rx_ack = 1'b1;
            @(negedge clk);
            rx_if.rx_ack = 1'b0;
         end
      join
      chk("race_ovr", overrun, 0);
      chk("race_valid", rx_if.rx_valid, 1);
      ack();

      bd = 16'd1;
      for (int i = 0; i < 3; i++) begin
         rb = 8'($urandom);
         push(rb, 1, 0, 0);
         send(rb, 1'b1);
         ack();
      end

      push(8'h77, 1, 0, 0);
      send(8'h77, 1'b1);
      fork
         send(8'hFF, 1'b1);
         begin
            repeat (16 * (int'(bd) + 1) * 3) @(negedge clk);
            #2 rst_n = 1'b0;
            #1;
            chk("mid_rst_data", rx_if.rx_data, 0);
            chk("mid_rst_valid", rx_if.rx_valid, 0);
            chk("mid_rst_ferr", frame_err, 0);
            chk("mid_rst_ovr", overrun, 0);
            chk("mid_rst_busy", busy, 0);
            repeat (3) @(negedge clk);
            rst_n = 1'b1;
         end
      join
      chk("after_rst_busy", busy, 0);
      chk("after_rst_valid", rx_if.rx_valid, 0);
      push(8'h12, 1, 0, 0);
      send(8'h12, 1'b1);
      chk("post_rst_ovr", overrun, 0);

      repeat (10) @(negedge clk);
      chk("sb_drained", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
